imem_loader: RTL and testbench

//  Writer side of the instruction memory: receives a byte stream (e.g. from a UART RX/debug

---
 rtl/imem_loader_if.sv | 23 ++
 rtl/imem_loader.sv | 85 ++++++++
 tb/tb_imem_loader.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: host byte stream, load control and instruction-memory write port
interface imem_loader_if #(parameter int ADDR_W = 8);
  logic              start;
  logic [ADDR_W:0]   num_words;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [31:0]       checksum;
  modport master (
    output start, num_words, byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, checksum
  );
  modport slave (
    input  start, num_words, byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, checksum
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles little-endian words from a byte stream and writes them to instruction memory
module imem_loader #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input logic         clk,
  input logic         rst,
  imem_loader_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2, ERR = 2'd3;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  logic [1:0]        state;
  logic [1:0]        bidx;
  logic [ADDR_W-1:0] widx;
  logic [ADDR_W:0]   nw;
  logic [23:0]       asm_q;
  logic [TW-1:0]     timer;
  logic              fin;
  logic              acc;
  logic              last;
  logic [31:0]       word;
  assign bus.byte_ready = state == LOAD;
  assign bus.cpu_hold   = state == LOAD || state == ERR;
  assign acc  = bus.byte_valid && bus.byte_ready;
  assign word = {bus.byte_data, asm_q};
  assign last = {1'b0, widx} == nw - 1'b1;
  // Load sequencing: start decode, byte assembly, word write, completion and idle timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      bidx         <= '0;
      widx         <= '0;
      nw           <= '0;
      asm_q        <= '0;
      timer        <= '0;
      fin          <= 1'b0;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      bus.done     <= 1'b0;
      bus.error    <= 1'b0;
      bus.checksum <= '0;
    end else begin
      bus.wr_en <= 1'b0;
      bus.done  <= 1'b0;
      if (state != LOAD && bus.start) begin
        bus.checksum <= '0;
        bus.error    <= 1'b0;
        widx         <= '0;
        bidx         <= '0;
        timer        <= '0;
        fin          <= 1'b0;
        nw           <= bus.num_words;
        if (bus.num_words == '0) begin
          state    <= DONE;
          bus.done <= 1'b1;
        end else if (bus.num_words > DEPTH) begin
          state     <= ERR;
          bus.error <= 1'b1;
        end else state <= LOAD;
      end else if (state == LOAD) begin
        if (fin) begin
          state    <= DONE;
          bus.done <= 1'b1;
        end else if (acc) begin
          timer <= '0;
          bidx  <= bidx + 1'b1;
          asm_q <= {bus.byte_data, asm_q[23:8]};
          if (bidx == 2'd3) begin
            bus.wr_en    <= 1'b1;
            bus.wr_addr  <= widx;
            bus.wr_data  <= word;
            bus.checksum <= bus.checksum + word;
            fin          <= last;
            if (!last) widx <= widx + 1'b1;
          end
        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          state     <= ERR;
          bus.error <= 1'b1;
        end else timer <= timer + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed scoreboard bench for imem_loader
module tb_imem_loader;
  localparam int AW = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  imem_loader_if #(.ADDR_W(AW)) bus();
  imem_loader #(.ADDR_W(AW), .TIMEOUT_CYCLES(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0;
  int failures = 0;
  logic [39:0] expq[$];
  logic wr_due = 1'b0;
  logic [31:0] sum = '0;
  logic [31:0] asm_w = '0;
  int bcnt = 0;
  logic [7:0] naddr = '0;
  logic [7:0] last_addr = '0;
  int wr_cnt = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // write-port monitor: every strobe must be due and match the head of the scoreboard
  always @(negedge clk) begin
    if (bus.wr_en || wr_due) begin
      chk("wr_en_timing", {63'd0, bus.wr_en}, {63'd0, wr_due});
      if (bus.wr_en) begin
        wr_cnt++;
        last_addr = bus.wr_addr;
        if (expq.size() == 0) chk("wr_unexpected", 64'(expq.size() == 0), 64'd0);
        else begin
          logic [39:0] e;
          e = expq.pop_front();
          chk("wr_addr", {56'd0, bus.wr_addr}, {56'd0, e[39:32]});
          chk("wr_data", {32'd0, bus.wr_data}, {32'd0, e[31:0]});
        end
      end
      wr_due = 1'b0;
    end
  end
  task automatic start_load(input int n, input bit fresh);
    bus.start = 1'b1;
    bus.num_words = 9'(n);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    if (fresh) begin
      bcnt = 0;
      sum = '0;
      naddr = '0;
      asm_w = '0;
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
    bus.byte_valid = 1'b1;
    bus.byte_data = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = bus.byte_ready;
      @(posedge clk);
      #1;
    end
    bus.byte_valid = 1'b0;
    if (!ok) chk("byte_accept_timeout", {63'd0, ok}, 64'd1);
    else begin
      asm_w = {b, asm_w[31:8]};
      bcnt++;
      if (bcnt == 4) begin
        expq.push_back({naddr, asm_w});
        sum += asm_w;
        naddr++;
        bcnt = 0;
        wr_due = 1'b1;
      end
    end
  endtask
  task automatic finish_chk(input string tag);
    @(negedge clk);
    chk({tag, "_done_early"}, {63'd0, bus.done}, 64'd0);
    chk({tag, "_hold_busy"}, {63'd0, bus.cpu_hold}, 64'd1);
    @(negedge clk);
    chk({tag, "_done"}, {63'd0, bus.done}, 64'd1);
    chk({tag, "_hold_rel"}, {62'd0, bus.cpu_hold, bus.byte_ready}, 64'd0);
    chk({tag, "_checksum"}, {32'd0, bus.checksum}, {32'd0, sum});
    @(negedge clk);
    chk({tag, "_done_pulse"}, {63'd0, bus.done}, 64'd0);
    chk({tag, "_checksum_hold"}, {32'd0, bus.checksum}, {32'd0, sum});
    chk({tag, "_queue"}, 64'(expq.size()), 64'd0);
  endtask
  initial begin
    logic [7:0] t1 [8];
    int wc;
    t1 = '{8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00};
    bus.start = 1'b0;
    bus.num_words = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {59'd0, bus.byte_ready, bus.wr_en, bus.cpu_hold, bus.done, bus.error}, 64'd0);
    chk("rst_data", {bus.wr_data, bus.checksum}, 64'd0);
    chk("rst_addr", {56'd0, bus.wr_addr}, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // directed two-word load, back-to-back bytes
    start_load(2, 1'b1);
    for (int i = 0; i < 8; i++) send_byte(t1[i], 0);
    finish_chk("t1");
    chk("t1_checksum_const", {32'd0, bus.checksum}, {32'd0, 32'h00500113 + 32'h00C00193});
    // four words with random inter-byte gaps
    wc = wr_cnt;
    start_load(4, 1'b1);
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), int'($urandom_range(0, 5)));
    finish_chk("t2");
    chk("t2_writes", 64'(wr_cnt - wc), 64'd4);
    // idle timeout with a partial word
    wc = wr_cnt;
    start_load(1, 1'b1);
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    repeat (6) @(negedge clk);
    chk("t3_no_early_err", {63'd0, bus.error}, 64'd0);
    for (int i = 0; i < 10 && !bus.error; i++) @(negedge clk);
    chk("t3_error", {63'd0, bus.error}, 64'd1);
    chk("t3_hold_rdy", {62'd0, bus.cpu_hold, bus.byte_ready}, 64'd2);
    chk("t3_no_write", 64'(wr_cnt - wc), 64'd0);
    repeat (3) @(negedge clk);
    chk("t3_err_sticky", {62'd0, bus.error, bus.cpu_hold}, 64'd3);
    @(posedge clk);
    #1;
    start_load(0, 1'b1);
    @(negedge clk);
    chk("t3_clear", {61'd0, bus.error, bus.done, bus.cpu_hold}, 64'd2);
    // zero and oversize word counts, then a full-depth load
    wc = wr_cnt;
    @(negedge clk);
    chk("t4_zero_pulse", {63'd0, bus.done}, 64'd0);
    @(posedge clk);
    #1;
    start_load(257, 1'b1);
    @(negedge clk);
    chk("t4_over_err", {61'd0, bus.error, bus.cpu_hold, bus.done}, 64'd6);
    chk("t4_over_rdy", {63'd0, bus.byte_ready}, 64'd0);
    @(posedge clk);
    #1;
    start_load(256, 1'b1);
    for (int i = 0; i < 1024; i++) send_byte(8'($urandom), 0);
    finish_chk("t4");
    chk("t4_last_addr", {56'd0, last_addr}, 64'hFF);
    chk("t4_writes", 64'(wr_cnt - wc), 64'd256);
    // start during LOAD is ignored
    start_load(2, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'(i + 1), 0);
    start_load(1, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'(i + 16), 0);
    finish_chk("t5_ignore");
    // reset in the middle of a load
    start_load(2, 1'b1);
    for (int i = 0; i < 5; i++) send_byte(8'(i + 32), 0);
    wc = wr_cnt;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_rst_ctrl", {59'd0, bus.byte_ready, bus.wr_en, bus.cpu_hold, bus.done, bus.error}, 64'd0);
    chk("t5_rst_data", {bus.wr_data, bus.checksum}, 64'd0);
    chk("t5_rst_addr", {56'd0, bus.wr_addr}, 64'd0);
    #1;
    rst = 1'b0;
    bus.byte_valid = 1'b1;
    repeat (4) @(negedge clk);
    bus.byte_valid = 1'b0;
    chk("t5_rst_nowr", 64'(wr_cnt - wc), 64'd0);
    chk("t5_idle_rdy", {63'd0, bus.byte_ready}, 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
